mult_div_ctrl: RTL and testbench
================================

Name: mult_div_ctrl

Overview:
- Multicycle multiply/divide sequencer that executes MULT, MULTU, DIV and DIVU and owns the HI/LO registers.
- Sits beside the ALU/shift block in the multicycle datapath.
- The main control FSM issues a one-cycle `start` with operands from registers A and B, waits on `busy`/`done`, then reads HI/LO for MFHI/MFLO.
- Multiply uses iterative shift-add. Divide is restoring division on magnitudes, followed by a sign fix-up step.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- opA  in  WIDTH  multiplicand / dividend.
- opB  in  WIDTH  multiplier / divisor.
- busy  out  1  high from the cycle after start is accepted until DONE inclusive.
- done  out  1  one-cycle pulse; HI/LO are valid in the same cycle.
- div_zero  out  1  sticky flag: last DIV/DIVU had opB==0; cleared at the next accepted start.
- HI  out  WIDTH  high product word, or remainder.
- LO  out  WIDTH  low product word, or quotient.

Behaviour:
- Clock and reset: one clock `Clk`; reset is synchronous and active-high (`reset`).
- Reset values: state=IDLE, busy=0, done=0, div_zero=0, HI=0, LO=0, counter=0.
- Reset mid-operation aborts in the next cycle: no done pulse, HI/LO cleared.
- States: IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE.
- IDLE:
  - On start=1, latch op and operands at edge E0.
  - Signed ops latch operand magnitudes and record the result sign(s).
  - Clear div_zero and the counter.
  - Next state: MUL_RUN for op[1]=0. For op[1]=1: DONE if opB==0, else DIV_RUN.
- MUL_RUN:
  - Per cycle: if multiplier LSB=1, add multiplicand into the upper accumulator (WIDTH+1-bit add).
  - Then shift the {acc, multiplier} pair right by 1. Counter increments.
  - After exactly WIDTH cycles (E1..E32 for WIDTH=32), go to DONE.
  - On that transition, write {HI,LO} = the 2*WIDTH product, two's-complement negated if the signs differ (MULT only).
- DIV_RUN:
  - Per cycle: shift {rem, quot} left by 1 and trial-subtract the divisor magnitude from rem.
  - If no borrow, keep the difference and set quot LSB=1; otherwise restore.
  - Runs WIDTH cycles, then goes to DIV_FIX.
- DIV_FIX (one cycle), signed DIV only:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Quotient truncates toward zero.
  - Write LO=quotient, HI=remainder; go to DONE.
- DONE: done=1, busy=1 for one cycle, then IDLE.
- Latency, start at E0:
  - MULT/MULTU: done during cycle 33.
  - DIV/DIVU: done during cycle 34.
  - Divide-by-zero: done during cycle 1.
- Divide-by-zero: div_zero=1, HI/LO unchanged, no iterations run.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, no error flag.
- start while busy=1 is ignored; the operation in flight is unaffected.
- start asserted in the DONE cycle is ignored. Back-to-back issue is accepted in the IDLE cycle following DONE.
- HI/LO change only on the DONE transition (or reset). They hold their value indefinitely while idle.
- opA/opB may change after E0 without affecting the result.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at E0 → done pulse in cycle 33, HI=0xFFFFFFFE, LO=0x00000001, busy high cycles 1–33.
- MULT -7 (0xFFFFFFF9) x 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 → HI=0x40000000, LO=0.
- DIV -7 / 2 → done in cycle 34, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIV 5 / 0 after a prior MULTU leaving HI=0x11, LO=0x22 → done in cycle 1, div_zero=1, HI=0x11, LO=0x22. Next accepted start clears div_zero.
- MULT issued, second start with op=10 at cycle 10, opA/opB changed at cycle 5 → ignored; original product delivered at cycle 33. A start in the cycle after DONE is accepted.
- reset asserted in cycle 15 of DIV_RUN → next cycle busy=0, done=0, HI=LO=0; no done pulse follows. A fresh MULTU 3 x 4 then yields LO=12, HI=0.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multicycle multiply/divide sequencer that owns HI/LO.
// Multiply is iterative shift-add, one multiplier bit per cycle. Divide is
// restoring division on operand magnitudes, followed by a sign fix-up cycle.
//
// Ports:
//   Clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   start     request pulse, honoured only in IDLE
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opA/opB   multiplicand/dividend and multiplier/divisor, latched on accept
//   busy      high from the cycle after accept through the DONE cycle
//   done      one-cycle pulse, HI/LO valid in the same cycle
//   div_zero  sticky: last DIV/DIVU had a zero divisor; cleared on next accept
//   HI/LO     product high/low word, or remainder/quotient
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; HI/LO hold their last result
// MUL_RUN | WIDTH shift-add iterations
// DIV_RUN | WIDTH restoring-division iterations
// DIV_FIX | apply quotient/remainder signs, write HI/LO
// DONE    | done pulse, then back to IDLE

module mult_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_RUN,
        S_DIV_RUN,
        S_DIV_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t state, state_nxt;

    // opnd holds the multiplicand or divisor magnitude. upr/lwr are the
    // {accumulator, multiplier} pair for multiply and {remainder, quotient}
    // for divide.
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] upr;
    logic [WIDTH-1:0] lwr;
    logic [CNT_W-1:0] cnt;
    logic             neg_lo;
    logic             neg_hi;

    logic             last_iter;
    logic             is_signed;
    logic             div_by_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_upr;
    logic [WIDTH-1:0]   mul_lwr;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;

    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_upr;
    logic [WIDTH-1:0] div_lwr;

    assign last_iter   = (cnt == LAST_ITER);
    assign is_signed   = ~op[0];
    assign div_by_zero = op[1] && (opB == '0);
    assign mag_a       = (is_signed && opA[WIDTH-1]) ? -opA : opA;
    assign mag_b       = (is_signed && opB[WIDTH-1]) ? -opB : opB;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Shift-add step: the extra sum bit carries into the shifted accumulator.
    assign mul_sum     = {1'b0, upr} + (lwr[0] ? {1'b0, opnd} : '0);
    assign mul_upr     = mul_sum[WIDTH:1];
    assign mul_lwr     = {mul_sum[0], lwr[WIDTH-1:1]};
    assign product     = {mul_upr, mul_lwr};
    assign product_fix = neg_lo ? -product : product;

    // Restoring step: the remainder stays below the divisor, so the shifted
    // value needs only one extra bit.
    assign div_sh   = {upr, lwr[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, opnd});
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_upr  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_lwr  = {lwr[WIDTH-2:0], div_ge};

    always_ff @(posedge Clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!op[1])           state_nxt = S_MUL_RUN;
                    else if (div_by_zero) state_nxt = S_DONE;
                    else                  state_nxt = S_DIV_RUN;
                end
            end
            S_MUL_RUN: if (last_iter) state_nxt = S_DONE;
            S_DIV_RUN: if (last_iter) state_nxt = S_DIV_FIX;
            S_DIV_FIX: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            opnd     <= '0;
            upr      <= '0;
            lwr      <= '0;
            cnt      <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opnd     <= op[1] ? mag_b : mag_a;
                        lwr      <= op[1] ? mag_a : mag_b;
                        upr      <= '0;
                        cnt      <= '0;
                        div_zero <= div_by_zero;
                        // Quotient/product sign differs; remainder follows dividend.
                        neg_lo   <= is_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        neg_hi   <= is_signed && op[1] && opA[WIDTH-1];
                    end
                end
                S_MUL_RUN: begin
                    upr <= mul_upr;
                    lwr <= mul_lwr;
                    cnt <= cnt + 1'b1;
                    if (last_iter) {HI, LO} <= product_fix;
                end
                S_DIV_RUN: begin
                    upr <= div_upr;
                    lwr <= div_lwr;
                    cnt <= cnt + 1'b1;
                end
                S_DIV_FIX: begin
                    LO <= neg_lo ? -lwr : lwr;
                    HI <= neg_hi ? -upr : upr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: directed and random checks of mult_div_ctrl against an
// arithmetic reference model (64-bit products, native signed division).

module tb_mult_div_ctrl;

    logic        Clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dz = 1'b0;

    mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .opA      (opA),
        .opB      (opB),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: updates m_hi/m_lo/m_dz and returns the done cycle.
    task automatic model_op(input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, output int lat);
        int          sa, sb;
        longint      p, q, r;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                {m_hi, m_lo} = p;
                m_dz = 1'b0;
                lat = 33;
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                {m_hi, m_lo} = up;
                m_dz = 1'b0;
                lat = 33;
            end
            default: begin
                if (b == 0) begin
                    m_dz = 1'b1;
                    lat = 1;
                end else if (o == 2'b10) begin
                    q = longint'(sa) / longint'(sb);
                    r = longint'(sa) % longint'(sb);
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                    m_dz = 1'b0;
                    lat = 34;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                    m_dz = 1'b0;
                    lat = 34;
                end
            end
        endcase
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following
    // IDLE cycle, after poking start during DONE (which must be ignored).
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        int lat_exp;
        int n;
        model_op(o, a, b, lat_exp);
        op    = o;
        opA   = a;
        opB   = b;
        start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge Clk);
            n = i;
            if (done) break;
            chk({tag, " busy"}, busy, 1'b1);
            opA = $urandom;
            opB = $urandom;
            if (disturb && i == 10) begin
                start = 1'b1;
                op    = 2'b10;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, " latency"}, n, lat_exp);
        chk({tag, " busy_at_done"}, busy, 1'b1);
        chk({tag, " HI"}, HI, m_hi);
        chk({tag, " LO"}, LO, m_lo);
        chk({tag, " div_zero"}, div_zero, m_dz);
        // start during DONE must not launch a new operation
        start = 1'b1;
        op    = 2'b01;
        opA   = $urandom;
        opB   = $urandom;
        @(negedge Clk);
        start = 1'b0;
        chk({tag, " idle_after_done"}, busy, 1'b0);
        chk({tag, " HI_hold"}, HI, m_hi);
        chk({tag, " LO_hold"}, LO, m_lo);
    endtask

    initial begin
        bit          seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        opA   = '0;
        opB   = '0;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst div_zero", div_zero, 1'b0);
        chk("rst HI", HI, 32'h0);
        chk("rst LO", LO, 32'h0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg7x3", 2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0);
        run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("multu_11_22", 2'b01, 32'h22, 32'h8000_0001, 1'b0);
        run_op("div_by_zero", 2'b10, 32'd5, 32'd0, 1'b0);
        run_op("dz_clear", 2'b01, 32'd9, 32'd9, 1'b0);
        run_op("mult_disturb", 2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        run_op("b2b", 2'b11, 32'hFFFF_FFFF, 32'd10, 1'b0);

        // Reset mid-division aborts the operation.
        op    = 2'b10;
        opA   = $urandom;
        opB   = $urandom | 32'h1;
        start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (15) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort HI", HI, 32'h0);
        chk("abort LO", LO, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (done) seen = 1'b1;
        end
        chk("abort no_done", seen, 1'b0);
        run_op("multu_3x4", 2'b01, 32'd3, 32'd4, 1'b0);

        for (int k = 0; k < 24; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            if ($urandom_range(0, 9) == 0) rb = 32'h0;
            run_op("random", ro, ra, rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
